// File: rtl/lr_scheduler.sv
// Step-decay learning-rate scheduler: walks LR_index from 0 to LR_SIZE (zero rate)
// every STEPS_PER_LR accepted steps; define LR_PLATEAU_EN to add loss-plateau early decay.
module lr_scheduler #(
    parameter int LR_SIZE      = 7,
    parameter int STEPS_PER_LR = 4,
    parameter int PATIENCE     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         step_valid,
`ifdef LR_PLATEAU_EN
    input  logic                         loss_up,
`endif
    output logic [$clog2(LR_SIZE+1)-1:0] LR_index,
    output logic                         busy,
    output logic                         lr_step,
    output logic                         sched_done,
    output logic [1:0]                   fsm_state
);

    localparam int IW = $clog2(LR_SIZE+1);
    localparam int CW = $clog2(STEPS_PER_LR+1);

    localparam logic [IW-1:0] IDX_LAST = IW'(LR_SIZE - 1);
    localparam logic [IW-1:0] IDX_ZERO = IW'(LR_SIZE);
    localparam logic [CW-1:0] CNT_LAST = CW'(STEPS_PER_LR - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          step_d;
    logic          step_hit;
    logic          plat_hit;
    logic          decay;

`ifdef LR_PLATEAU_EN
    localparam int PW = $clog2(PATIENCE+1);
    localparam logic [PW-1:0] PLAT_LAST = PW'(PATIENCE - 1);
    logic [PW-1:0] plat_q, plat_d;

    assign plat_hit = loss_up && (plat_q == PLAT_LAST);
`else
    assign plat_hit = 1'b0;
`endif

    assign step_hit = (cnt_q == CNT_LAST);
    assign decay    = step_hit || plat_hit;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
`ifdef LR_PLATEAU_EN
        plat_d  = plat_q;
`endif
        if (start) begin
            // start wins over a coincident step_valid, which is dropped
            state_d = RUN;
            idx_d   = '0;
            cnt_d   = '0;
`ifdef LR_PLATEAU_EN
            plat_d  = '0;
`endif
        end else if (state_q == RUN && step_valid) begin
`ifdef LR_PLATEAU_EN
            if (!loss_up)
                plat_d = '0;
            else if (plat_hit)
                plat_d = '0;
            else
                plat_d = plat_q + 1'b1;
`endif
            if (decay) begin
                cnt_d  = '0;
                step_d = 1'b1;
                idx_d  = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    idx_d   = IDX_ZERO;
                    state_d = DONE;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            LR_index   <= '0;
            busy       <= 1'b0;
            lr_step    <= 1'b0;
            sched_done <= 1'b0;
`ifdef LR_PLATEAU_EN
            plat_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            LR_index   <= idx_d;
            busy       <= (state_d == RUN);
            lr_step    <= step_d;
            sched_done <= (state_d == DONE);
`ifdef LR_PLATEAU_EN
            plat_q     <= plat_d;
`endif
        end
    end

    assign fsm_state = state_q;

endmodule
